// File: rtl/mmio_io_bank.sv
// mmio_io_bank
// Memory-mapped I/O bank on the CPU data bus. It drives the red and green LEDs
// and a configurable number of active-low seven-segment digits. It samples the
// switches and keys (keys are active-low) and latches key presses as sticky
// flags. It owns a UART receive FIFO and the transmit handshake, and combines
// the status and interrupt-enable registers into one registered level irq.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   addr, we, re, wdata   bus access; a register at BASE + offset
//   rdata                 registered read data, held until the next re
//   switches, keys        asynchronous inputs (keys active-low)
//   ledr, ledg, seg       LED and seven-segment outputs (seg active-low)
//   uart_rxd_data/_done   received byte and its one-cycle strobe
//   uart_txd_data         byte to transmit
//   uart_transmit         one-cycle start pulse to the transmitter
//   uart_txd_done         one-cycle pulse when the transmitter finishes
//   irq                   level interrupt to the CPU
module mmio_io_bank #(
  parameter logic [15:0] BASE     = 16'hFF00,
  parameter int          LEDR_W   = 8,
  parameter int          LEDG_W   = 8,
  parameter int          NUM_SEG  = 4,
  parameter int          SW_W     = 8,
  parameter int          KEY_N    = 4,
  parameter int          RX_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            addr,
  input  logic                   we,
  input  logic                   re,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  input  logic [SW_W-1:0]        switches,
  input  logic [KEY_N-1:0]       keys,
  output logic [LEDR_W-1:0]      ledr,
  output logic [LEDG_W-1:0]      ledg,
  output logic [7*NUM_SEG-1:0]   seg,
  input  logic [7:0]             uart_rxd_data,
  input  logic                   uart_rxd_done,
  output logic [7:0]             uart_txd_data,
  output logic                   uart_transmit,
  input  logic                   uart_txd_done,
  output logic                   irq
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OFF_LEDR    = 4'h0;
  localparam logic [3:0] OFF_LEDG    = 4'h1;
  localparam logic [3:0] OFF_SW      = 4'h8;
  localparam logic [3:0] OFF_KEY     = 4'h9;
  localparam logic [3:0] OFF_KEYEDGE = 4'hA;
  localparam logic [3:0] OFF_TXD     = 4'hB;
  localparam logic [3:0] OFF_RXD     = 4'hC;
  localparam logic [3:0] OFF_STAT    = 4'hD;
  localparam logic [3:0] OFF_IRQEN   = 4'hE;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [LEDR_W-1:0] ledr_r;
  logic [LEDG_W-1:0] ledg_r;
  logic [6:0]        seg_r [NUM_SEG];
  logic [SW_W-1:0]   sw_sync1_r, sw_sync2_r;
  logic [KEY_N-1:0]  key_sync1_r, key_sync2_r, key_prev_r;
  logic [KEY_N-1:0]  keyedge_r;
  logic [7:0]        irqen_r;
  logic [7:0]        rdata_r;
  logic [7:0]        txd_data_r;
  logic              transmit_r;
  logic              tx_busy_r;
  logic              tx_err_r;
  logic              rx_ovf_r;
  logic              irq_r;
  logic [7:0]        fifo_mem_r [RX_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;

  // ---------------------------------------------------------------------------
  // Address decode: the offset is the distance from BASE, valid below 16
  // ---------------------------------------------------------------------------
  logic [15:0] rel_s;
  logic        hit_s;
  logic [3:0]  off_s;
  logic        wr_s, rd_s;

  assign rel_s = addr - BASE;
  assign hit_s = (rel_s[15:4] == 12'h000);
  assign off_s = rel_s[3:0];
  assign wr_s  = we & hit_s;
  assign rd_s  = re & hit_s;

  // ---------------------------------------------------------------------------
  // Derived status and control strobes
  // ---------------------------------------------------------------------------
  logic             rx_not_empty_s, rx_full_s;
  logic             pop_s, push_ok_s, ovf_set_s;
  logic             txd_wr_s, tx_accept_s, tx_err_set_s;
  logic [KEY_N-1:0] key_press_s, key_clr_s;
  logic [7:0]       stat_s;
  logic             irq_s;

  assign rx_not_empty_s = (count_r != {CW{1'b0}});
  assign rx_full_s      = (count_r == CW'(RX_DEPTH));
  assign stat_s         = {3'b000, tx_err_r, tx_busy_r, rx_ovf_r, rx_full_s, rx_not_empty_s};

  // Strobe generation for FIFO, transmitter and key flags
  always_comb begin
    pop_s        = rd_s & (off_s == OFF_RXD) & rx_not_empty_s;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    push_ok_s    = uart_rxd_done & (~rx_full_s | pop_s);
    ovf_set_s    = uart_rxd_done & rx_full_s & ~pop_s;
    txd_wr_s     = wr_s & (off_s == OFF_TXD);
    // A done pulse in the same cycle frees the transmitter for this write.
    tx_accept_s  = txd_wr_s & (~tx_busy_r | uart_txd_done);
    tx_err_set_s = txd_wr_s & tx_busy_r & ~uart_txd_done;
    key_press_s  = key_prev_r & ~key_sync2_r;
    if (wr_s && (off_s == OFF_KEYEDGE)) begin
      key_clr_s = wdata[KEY_N-1:0];
    end else begin
      key_clr_s = {KEY_N{1'b0}};
    end
    irq_s = (irqen_r[0] & (|keyedge_r))
          | (irqen_r[1] & stat_s[0])
          | (irqen_r[2] & ~stat_s[3])
          | (irqen_r[3] & (stat_s[2] | stat_s[4]));
  end

  // ---------------------------------------------------------------------------
  // Read data multiplexer (zero-extends narrow registers)
  // ---------------------------------------------------------------------------
  logic [7:0] ledr_pad_s, ledg_pad_s, sw_pad_s, key_pad_s, keyedge_pad_s;
  logic [7:0] seg_rd_s, rd_val_s;
  logic       seg_hit_s;

  // Zero-extension of the narrow registers to the 8-bit bus
  always_comb begin
    ledr_pad_s                   = 8'h00;
    ledr_pad_s[LEDR_W-1:0]       = ledr_r;
    ledg_pad_s                   = 8'h00;
    ledg_pad_s[LEDG_W-1:0]       = ledg_r;
    sw_pad_s                     = 8'h00;
    sw_pad_s[SW_W-1:0]           = sw_sync2_r;
    key_pad_s                    = 8'h00;
    key_pad_s[KEY_N-1:0]         = ~key_sync2_r;
    keyedge_pad_s                = 8'h00;
    keyedge_pad_s[KEY_N-1:0]     = keyedge_r;
  end

  // Segment readback: find the digit whose offset matches
  always_comb begin
    seg_rd_s  = 8'h00;
    seg_hit_s = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (off_s == 4'(i + 2)) begin
        seg_rd_s  = {1'b0, seg_r[i]};
        seg_hit_s = 1'b1;
      end else begin
        seg_rd_s  = seg_rd_s;
        seg_hit_s = seg_hit_s;
      end
    end
  end

  // Register read selection
  always_comb begin
    rd_val_s = 8'h00;
    if (hit_s) begin
      case (off_s)
        OFF_LEDR:    rd_val_s = ledr_pad_s;
        OFF_LEDG:    rd_val_s = ledg_pad_s;
        OFF_SW:      rd_val_s = sw_pad_s;
        OFF_KEY:     rd_val_s = key_pad_s;
        OFF_KEYEDGE: rd_val_s = keyedge_pad_s;
        OFF_RXD: begin
          if (rx_not_empty_s) begin
            rd_val_s = fifo_mem_r[rd_ptr_r];
          end else begin
            rd_val_s = 8'h00;
          end
        end
        OFF_STAT:    rd_val_s = stat_s;
        OFF_IRQEN:   rd_val_s = irqen_r;
        default: begin
          if (seg_hit_s) begin
            rd_val_s = seg_rd_s;
          end else begin
            rd_val_s = 8'h00;
          end
        end
      endcase
    end else begin
      rd_val_s = 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Writable output registers: LEDs, segment digits, interrupt enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledr_r  <= {LEDR_W{1'b0}};
      ledg_r  <= {LEDG_W{1'b0}};
      irqen_r <= 8'h00;
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_r[i] <= 7'h7F;
      end
    end else begin
      if (wr_s && (off_s == OFF_LEDR))  ledr_r  <= wdata[LEDR_W-1:0];
      if (wr_s && (off_s == OFF_LEDG))  ledg_r  <= wdata[LEDG_W-1:0];
      if (wr_s && (off_s == OFF_IRQEN)) irqen_r <= wdata;
      for (int i = 0; i < NUM_SEG; i++) begin
        if (wr_s && (off_s == 4'(i + 2))) seg_r[i] <= wdata[6:0];
      end
    end
  end

  // Input synchronisers and key press flags; keys reset to the released level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1_r  <= {SW_W{1'b0}};
      sw_sync2_r  <= {SW_W{1'b0}};
      key_sync1_r <= {KEY_N{1'b1}};
      key_sync2_r <= {KEY_N{1'b1}};
      key_prev_r  <= {KEY_N{1'b1}};
      keyedge_r   <= {KEY_N{1'b0}};
    end else begin
      sw_sync1_r  <= switches;
      sw_sync2_r  <= sw_sync1_r;
      key_sync1_r <= keys;
      key_sync2_r <= key_sync1_r;
      key_prev_r  <= key_sync2_r;
      // A new press wins over a simultaneous clear of the same bit.
      keyedge_r   <= (keyedge_r & ~key_clr_s) | key_press_s;
    end
  end

  // RX FIFO storage; no reset needed, validity is tracked by the count
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= uart_rxd_data;
    end
  end

  // RX FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      rx_ovf_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        rx_ovf_r <= 1'b1;
      end else if (wr_s && (off_s == OFF_STAT) && wdata[2]) begin
        rx_ovf_r <= 1'b0;
      end
    end
  end

  // Transmit handshake: data latch, start pulse, busy and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_data_r <= 8'h00;
      transmit_r <= 1'b0;
      tx_busy_r  <= 1'b0;
      tx_err_r   <= 1'b0;
    end else begin
      transmit_r <= tx_accept_s;
      if (tx_accept_s) begin
        txd_data_r <= wdata;
        tx_busy_r  <= 1'b1;
      end else if (uart_txd_done) begin
        tx_busy_r  <= 1'b0;
      end
      if (tx_err_set_s) begin
        tx_err_r <= 1'b1;
      end else if (wr_s && (off_s == OFF_STAT) && wdata[4]) begin
        tx_err_r <= 1'b0;
      end
    end
  end

  // Read data register (held between reads) and registered interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 8'h00;
      irq_r   <= 1'b0;
    end else begin
      if (re) rdata_r <= rd_val_s;
      irq_r <= irq_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ledr          = ledr_r;
  assign ledg          = ledg_r;
  assign rdata         = rdata_r;
  assign uart_txd_data = txd_data_r;
  assign uart_transmit = transmit_r;
  assign irq           = irq_r;

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    assign seg[7*g +: 7] = seg_r[g];
  end

endmodule

// File: tb/tb_mmio_io_bank.sv
// Testbench for mmio_io_bank. Bus reads push their expected byte into a
// scoreboard queue; a monitor compares rdata the cycle after each read strobe.
// Direct output checks (LEDs, segments, irq, UART) use the same counters.
module tb_mmio_io_bank;

  logic        clk, rst;
  logic [15:0] addr;
  logic        we, re;
  logic [7:0]  wdata, rdata;
  logic [7:0]  switches;
  logic [3:0]  keys;
  logic [7:0]  ledr, ledg;
  logic [27:0] seg;
  logic [7:0]  uart_rxd_data;
  logic        uart_rxd_done;
  logic [7:0]  uart_txd_data;
  logic        uart_transmit;
  logic        uart_txd_done;
  logic        irq;

  mmio_io_bank dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .switches(switches), .keys(keys), .ledr(ledr), .ledg(ledg),
    .seg(seg), .uart_rxd_data(uart_rxd_data), .uart_rxd_done(uart_rxd_done),
    .uart_txd_data(uart_txd_data), .uart_transmit(uart_transmit),
    .uart_txd_done(uart_txd_done), .irq(irq)
  );

  localparam logic [15:0] A_LEDR = 16'hFF00, A_LEDG = 16'hFF01, A_SEG1 = 16'hFF03;
  localparam logic [15:0] A_SW = 16'hFF08, A_KEY = 16'hFF09, A_KEYEDGE = 16'hFF0A;
  localparam logic [15:0] A_TXD = 16'hFF0B, A_RXD = 16'hFF0C, A_STAT = 16'hFF0D;
  localparam logic [15:0] A_IRQEN = 16'hFF0E;

  int errors = 0;
  int checks = 0;
  int tx_pulses = 0;

  logic [7:0]  exp_q [$];
  logic [15:0] addr_q [$];
  logic        re_d;
  logic [7:0]  mon_exp;
  logic [15:0] mon_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read strobe delayed to the cycle in which rdata is valid
  always @(posedge clk) re_d <= re;

  // Scoreboard monitor: compare rdata with the oldest pending expectation
  always @(negedge clk) begin
    if (re_d === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h with no expected value", rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_addr = addr_q.pop_front();
        if (rdata !== mon_exp) begin
          errors++;
          $display("FAIL rd@%h: got %h expected %h", mon_addr, rdata, mon_exp);
        end
      end
    end
  end

  // Count start pulses to the transmitter
  always @(negedge clk) if (uart_transmit === 1'b1) tx_pulses++;

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] e);
    @(negedge clk);
    addr = a; re = 1'b1;
    exp_q.push_back(e); addr_q.push_back(a);
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(negedge clk);
    uart_rxd_data = d; uart_rxd_done = 1'b1;
    @(negedge clk);
    uart_rxd_done = 1'b0;
  endtask

  task automatic tx_done();
    @(negedge clk);
    uart_txd_done = 1'b1;
    @(negedge clk);
    uart_txd_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; addr = 16'h0000; we = 1'b0; re = 1'b0; wdata = 8'h00;
    switches = 8'hA5; keys = 4'hF; uart_rxd_data = 8'h00; uart_rxd_done = 1'b0;
    uart_txd_done = 1'b0;
    idle(3);
    // Reset state
    check("rst_ledr", ledr, 8'h00);
    check("rst_ledg", ledg, 8'h00);
    check("rst_seg", seg, 28'hFFFFFFF);
    check("rst_rdata", rdata, 8'h00);
    check("rst_txd", uart_txd_data, 8'h00);
    check("rst_transmit", uart_transmit, 1'b0);
    check("rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // LED / SEG / decode
    bus_write(A_LEDR, 8'h5A);
    bus_write(A_SEG1, 8'h3F);
    check("ledr", ledr, 8'h5A);
    check("seg1", seg[13:7], 7'h3F);
    check("seg0_blank", seg[6:0], 7'h7F);
    bus_read(A_LEDR, 8'h5A);
    bus_read(A_SEG1, 8'h3F);
    bus_write(A_LEDG, 8'hC3);
    bus_read(A_LEDG, 8'hC3);
    bus_read(16'hFF06, 8'h00);
    bus_read(16'hFF0F, 8'h00);
    bus_read(16'hFF10, 8'h00);
    bus_read(A_SW, 8'hA5);
    bus_write(A_SW, 8'hFF);
    bus_read(A_SW, 8'hA5);
    bus_read(A_KEYEDGE, 8'h00);

    // Key edge and key interrupt
    bus_write(A_IRQEN, 8'h01);
    @(negedge clk);
    keys = 4'b1011;
    idle(3);
    bus_read(A_KEY, 8'h04);
    keys = 4'hF;
    idle(2);
    check("key_irq_set", irq, 1'b1);
    bus_read(A_KEYEDGE, 8'h04);
    bus_write(A_KEYEDGE, 8'h04);
    @(negedge clk);
    check("key_irq_clr", irq, 1'b0);
    bus_read(A_KEYEDGE, 8'h00);
    bus_write(A_IRQEN, 8'h00);

    // RX FIFO fill past full
    for (int i = 0; i < 9; i++) rx_push(8'(8'h10 + i));
    bus_read(A_STAT, 8'h07);
    for (int i = 0; i < 8; i++) bus_read(A_RXD, 8'(8'h10 + i));
    bus_read(A_RXD, 8'h00);
    bus_read(A_STAT, 8'h04);
    bus_write(A_STAT, 8'h04);
    bus_read(A_STAT, 8'h00);

    // Full FIFO with pop and push in the same cycle
    for (int i = 0; i < 8; i++) rx_push(8'(8'h20 + i));
    bus_read(A_STAT, 8'h03);
    @(negedge clk);
    addr = A_RXD; re = 1'b1; exp_q.push_back(8'h20); addr_q.push_back(A_RXD);
    uart_rxd_data = 8'hAA; uart_rxd_done = 1'b1;
    @(negedge clk);
    re = 1'b0; uart_rxd_done = 1'b0;
    bus_read(A_STAT, 8'h03);
    for (int i = 1; i < 8; i++) bus_read(A_RXD, 8'(8'h20 + i));
    bus_read(A_RXD, 8'hAA);
    bus_read(A_STAT, 8'h00);

    // TX handshake with !tx_busy interrupt
    bus_write(A_IRQEN, 8'h04);
    @(negedge clk);
    check("irq_idle_tx", irq, 1'b1);
    tx_pulses = 0;
    bus_write(A_TXD, 8'h41);
    idle(4);
    check("tx_pulse_once", tx_pulses, 1);
    check("txd_data", uart_txd_data, 8'h41);
    check("irq_busy_tx", irq, 1'b0);
    bus_read(A_STAT, 8'h08);
    tx_pulses = 0;
    bus_write(A_TXD, 8'h42);
    idle(3);
    check("tx_busy_no_pulse", tx_pulses, 0);
    check("txd_hold", uart_txd_data, 8'h41);
    bus_read(A_STAT, 8'h18);
    tx_done();
    @(negedge clk);
    check("irq_tx_done", irq, 1'b1);
    bus_read(A_STAT, 8'h10);
    bus_write(A_STAT, 8'h10);
    bus_read(A_STAT, 8'h00);
    bus_write(A_TXD, 8'h55);
    bus_read(A_STAT, 8'h08);
    // done and a new write in the same cycle: the write is accepted
    tx_pulses = 0;
    @(negedge clk);
    addr = A_TXD; wdata = 8'h66; we = 1'b1; uart_txd_done = 1'b1;
    @(negedge clk);
    we = 1'b0; uart_txd_done = 1'b0;
    idle(2);
    check("tx_done_write_pulse", tx_pulses, 1);
    check("tx_done_write_data", uart_txd_data, 8'h66);
    bus_read(A_STAT, 8'h08);

    // Reset while transmitting
    bus_write(A_TXD, 8'h77);
    bus_write(A_IRQEN, 8'h08);
    bus_write(A_LEDR, 8'hF0);
    bus_read(A_STAT, 8'h18);
    @(negedge clk);
    check("pre_rst_irq", irq, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_ledr", ledr, 8'h00);
    check("arst_seg", seg, 28'hFFFFFFF);
    check("arst_rdata", rdata, 8'h00);
    check("arst_txd", uart_txd_data, 8'h00);
    check("arst_irq", irq, 1'b0);
    idle(2);
    rst = 1'b0;
    bus_read(A_STAT, 8'h00);
    bus_read(A_IRQEN, 8'h00);
    bus_read(A_KEYEDGE, 8'h00);
    idle(3);
    check("queue_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
